// File: rtl/ddr_rd_fetch_if.sv
// Read command/data channel between ddr_rd_fetch (master) and the DDR2 memory
// manager user port (slave).
interface ddr_rd_fetch_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_req, rd_addr,
    input  rd_ack, rd_valid, rd_data
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/ddr_rd_fetch.sv
// DDR2 read-burst fetcher: issues num_bursts read commands from base_addr and
// streams returned words through a FWFT FIFO. Optional burst timeout: RD_TIMEOUT_EN.
module ddr_rd_fetch #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 32,
  parameter int BURST_WORDS = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               mem_clk_s,
  input  logic               mem_rst_s_n,
  input  logic               mem_init_done,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [15:0]        num_bursts,
  output logic               busy,
  output logic               done,
  ddr_rd_fetch_if.master     rd_if,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic               err_timeout
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WC_W  = $clog2(BURST_WORDS);

  if (FIFO_DEPTH < 2 * BURST_WORDS || TIMEOUT_CYC < 1) begin : g_cfg_err
    $error("ddr_rd_fetch: FIFO_DEPTH must be >= 2*BURST_WORDS and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPACE = 3'd1,
    REQ        = 3'd2,
    DATA       = 3'd3,
    NEXT       = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         remain_q, remain_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                req_q, req_d;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    free_slots;
  logic [DATA_W-1:0]   head_q, head_d;
  logic                vld_q, vld_d;

  logic                push, pop, last_word, start_ok, tmo_hit;

  assign push      = (state_q == DATA) && rd_if.rd_valid;
  assign pop       = out_ready && vld_q;
  assign last_word = push && (wcnt_q == WC_W'(BURST_WORDS - 1));
  assign start_ok  = (state_q == IDLE) && start && mem_init_done;
  assign free_slots = CNT_W'(FIFO_DEPTH) - cnt_q + CNT_W'(pop);

  // FIFO bookkeeping; the head register gives a registered FWFT output.
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    vld_d    = (cnt_d != '0);
    head_d   = head_q;
    if (cnt_d != '0) begin
      // Nothing else left after this cycle's pop: the new head is the word being pushed.
      if (cnt_q == CNT_W'(pop)) head_d = rd_if.rd_data;
      else                      head_d = mem_q[rd_ptr_d];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    wcnt_d   = wcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    req_d    = req_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          addr_d   = base_addr;
          remain_d = num_bursts;
          // busy is low in the cycle done pulses, so an empty transfer never raises it.
          if (num_bursts == 16'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (mem_init_done && free_slots >= CNT_W'(BURST_WORDS)) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (rd_if.rd_ack) begin
          req_d   = 1'b0;
          wcnt_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (push) wcnt_d = wcnt_q + WC_W'(1);
        if (last_word) begin
          state_d = NEXT;
        end else if (tmo_hit) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      NEXT: begin
        addr_d   = addr_q + ADDR_W'(BURST_WORDS);
        remain_d = remain_q - 16'd1;
        if (remain_q == 16'd1) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_SPACE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk_s or negedge mem_rst_s_n) begin
    if (!mem_rst_s_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      wcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      wcnt_q   <= wcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      req_q    <= req_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge mem_clk_s) begin
    if (push) mem_q[wr_ptr_q] <= rd_if.rd_data;
  end

`ifdef RD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_hit = (state_q == DATA) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_q == REQ && rd_if.rd_ack) tmo_d = '0;
    else if (state_q == DATA)           tmo_d = tmo_q + TMO_W'(1);
    if (start_ok)                       err_d = 1'b0;
    if (tmo_hit && !last_word)          err_d = 1'b1;
  end

  always_ff @(posedge mem_clk_s or negedge mem_rst_s_n) begin
    if (!mem_rst_s_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_if.rd_req  = req_q;
  assign rd_if.rd_addr = addr_q;
  assign out_valid     = vld_q;
  assign out_data      = head_q;

endmodule

// File: tb/tb_ddr_rd_fetch.sv
// Scoreboard bench for ddr_rd_fetch: a memory-manager stub answers read commands,
// monitors compare issued addresses and streamed words against queued expectations.
module tb_ddr_rd_fetch;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   num_bursts = '0;
  logic          busy, done, out_valid, err_timeout;
  logic [DW-1:0] out_data;

  ddr_rd_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) rd_if ();

  ddr_rd_fetch #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_WORDS(BW), .FIFO_DEPTH(FD), .TIMEOUT_CYC(255)
  ) dut (
    .mem_clk_s(clk), .mem_rst_s_n(rst_n), .mem_init_done(init_done),
    .start(start), .base_addr(base_addr), .num_bursts(num_bursts),
    .busy(busy), .done(done), .rd_if(rd_if),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] alist[$];
  int  cmd_cnt = 0;
  int  done_cnt = 0;
  bit  model_en = 1'b1;
  int  model_words = BW;

  function automatic logic [DW-1:0] wd(input logic [AW-1:0] a);
    return {7'h35, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Memory-manager stub: ack 2 cycles after rd_req, data 5 cycles after ack.
  initial begin : mem_model
    int phase, cnt, widx;
    logic [AW-1:0] a;
    phase = 0; cnt = 0; widx = 0; a = '0;
    rd_if.rd_ack = 1'b0; rd_if.rd_valid = 1'b0; rd_if.rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!model_en) begin
        phase = 0;
        continue;
      end
      rd_if.rd_ack = 1'b0;
      rd_if.rd_valid = 1'b0;
      if (!rst_n) begin
        phase = 0;
        continue;
      end
      if (phase == 0) begin
        if (rd_if.rd_req) begin cnt = 0; phase = 1; end
      end else if (phase == 1) begin
        cnt++;
        if (cnt == 2) begin rd_if.rd_ack = 1'b1; a = rd_if.rd_addr; cnt = 0; phase = 2; end
      end else if (phase == 2) begin
        cnt++;
        if (cnt == 5) begin widx = 0; phase = 3; end
      end
      if (phase == 3) begin
        rd_if.rd_valid = 1'b1;
        rd_if.rd_data  = wd(a + AW'(widx));
        widx++;
        if (widx == model_words) phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (rd_if.rd_req && rd_if.rd_ack) begin
        cmd_cnt++;
        if (exp_addr_q.size() == 0) fail_now("unexpected_rd_cmd");
        else check("rd_addr", 64'(rd_if.rd_addr), 64'(exp_addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) fail_now("unexpected_out_word");
        else check("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [AW-1:0] base, input logic [15:0] nb, input int words);
    foreach (alist[k]) begin
      exp_addr_q.push_back(alist[k]);
      for (int i = 0; i < words; i++) exp_data_q.push_back(wd(alist[k] + AW'(i)));
    end
    base_addr = base; num_bursts = nb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n0, i;
    n0 = done_cnt; i = 0;
    while (done_cnt == n0 && i < budget) begin @(posedge clk); i++; end
    if (done_cnt == n0) fail_now(name);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(busy), 64'(0));
    check({tag, "_done"},      64'(done), 64'(0));
    check({tag, "_rd_req"},    64'(rd_if.rd_req), 64'(0));
    check({tag, "_rd_addr"},   64'(rd_if.rd_addr), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_data"},  64'(out_data), 64'(0));
    check({tag, "_err"},       64'(err_timeout), 64'(0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, d0, n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1; init_done = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // Basic 3-burst transfer, consumer always ready.
    d0 = done_cnt;
    alist = '{25'h100, 25'h104, 25'h108};
    issue(25'h100, 16'd3, BW);
    @(negedge clk);
    check("start_busy", 64'(busy), 64'(1));
    check("start_req_cyc1", 64'(rd_if.rd_req), 64'(0));
    @(negedge clk);
    check("start_req_cyc2", 64'(rd_if.rd_req), 64'(1));
    wait_done(300, "t1_done_timeout");
    repeat (10) @(posedge clk);
    #1;
    check("t1_done_pulses", 64'(done_cnt - d0), 64'(1));
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_words_left", 64'(exp_data_q.size()), 64'(0));

    // Consumer stalled: FIFO fills after 4 bursts, then resumes.
    out_ready = 1'b0;
    c0 = cmd_cnt;
    alist = '{25'h200, 25'h204, 25'h208, 25'h20C, 25'h210, 25'h214};
    issue(25'h200, 16'd6, BW);
    repeat (120) @(posedge clk);
    #1;
    check("t2_cmds_stalled", 64'(cmd_cnt - c0), 64'(4));
    check("t2_req_low", 64'(rd_if.rd_req), 64'(0));
    check("t2_busy", 64'(busy), 64'(1));
    check("t2_out_valid", 64'(out_valid), 64'(1));
    check("t2_head", 64'(out_data), 64'(wd(25'h200)));
    out_ready = 1'b1;
    wait_done(400, "t2_done_timeout");
    repeat (10) @(posedge clk);
    #1;
    check("t2_cmds_total", 64'(cmd_cnt - c0), 64'(6));
    check("t2_words_left", 64'(exp_data_q.size()), 64'(0));

    // Zero bursts: done one cycle after start, no command.
    c0 = cmd_cnt; d0 = done_cnt;
    alist = {};
    issue(25'h500, 16'd0, BW);
    @(negedge clk);
    check("t3_done", 64'(done), 64'(1));
    check("t3_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("t3_done_drop", 64'(done), 64'(0));
    repeat (20) @(posedge clk);
    #1;
    check("t3_no_cmd", 64'(cmd_cnt - c0), 64'(0));
    check("t3_one_done", 64'(done_cnt - d0), 64'(1));

    // Reset during burst 2 data, then stray words after release.
    c0 = cmd_cnt;
    alist = '{25'h300, 25'h304, 25'h308};
    issue(25'h300, 16'd3, BW);
    n = 0;
    while (cmd_cnt < c0 + 2 && n < 200) begin @(posedge clk); n++; end
    if (cmd_cnt < c0 + 2) fail_now("t4_cmd_timeout");
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0; model_en = 1'b0;
    rd_if.rd_ack = 1'b0; rd_if.rd_valid = 1'b0;
    exp_data_q.delete(); exp_addr_q.delete();
    #1;
    check_reset_outputs("in_reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      rd_if.rd_valid = 1'b1; rd_if.rd_data = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
      check("t4_stray_out_valid", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #2;
    rd_if.rd_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");
    model_en = 1'b1;

    // Address wrap at the top of the address space.
    alist = '{25'h1FFFFFC, 25'h0000000};
    issue(25'h1FFFFFC, 16'd2, BW);
    wait_done(300, "t5_done_timeout");
    repeat (10) @(posedge clk);
    #1;
    check("t5_words_left", 64'(exp_data_q.size()), 64'(0));
    check("t5_addrs_left", 64'(exp_addr_q.size()), 64'(0));

`ifdef RD_TIMEOUT_EN
    // Short burst: only 2 of 4 words arrive, timeout abandons the transfer.
    out_ready = 1'b0; model_words = 2;
    alist = '{25'h400};
    issue(25'h400, 16'd2, 2);
    wait_done(400, "t6_done_timeout");
    @(negedge clk);
    check("t6_err", 64'(err_timeout), 64'(1));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_out_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    out_ready = 1'b1; model_words = BW;
    repeat (5) @(posedge clk);
    #1;
    check("t6_words_left", 64'(exp_data_q.size()), 64'(0));
    check("t6_fifo_empty", 64'(out_valid), 64'(0));
    alist = {};
    issue(25'h500, 16'd0, BW);
    @(negedge clk);
    check("t6_err_cleared", 64'(err_timeout), 64'(0));
`else
    check("err_tied_low", 64'(err_timeout), 64'(0));
`endif

    repeat (5) @(posedge clk);
    check("final_exp_words", 64'(exp_data_q.size()), 64'(0));
    check("final_exp_addrs", 64'(exp_addr_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
